// File: rtl/rank_window_ctrl.sv
// Streaming 3x3 window sequencer for rank_order: two line buffers, window shift,
// sorter-latency tracking and frame start/busy/done handshaking.
module rank_window_ctrl #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int DATA_W   = 8,
  parameter int SORT_LAT = 4
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic [3:0]        iOrderSel,
  input  logic [DATA_W-1:0] iPixel,
  input  logic              iValid,
  output logic [DATA_W-1:0] oNum1,
  output logic [DATA_W-1:0] oNum2,
  output logic [DATA_W-1:0] oNum3,
  output logic [DATA_W-1:0] oNum4,
  output logic [DATA_W-1:0] oNum5,
  output logic [DATA_W-1:0] oNum6,
  output logic [DATA_W-1:0] oNum7,
  output logic [DATA_W-1:0] oNum8,
  output logic [DATA_W-1:0] oNum9,
  output logic [3:0]        oOrder,
  output logic              oWinValid,
  input  logic [DATA_W-1:0] iSortValue,
  output logic [DATA_W-1:0] oPixel,
  output logic              oPixelValid,
  output logic              oBusy,
  output logic              oFrameDone
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]          state, nextState;
  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic                accept, lastCol;
  logic [DATA_W-1:0]   lb0 [IMG_W];
  logic [DATA_W-1:0]   lb1 [IMG_W];
  logic [DATA_W-1:0]   rdTop, rdMid;
  logic [SORT_LAT-1:0] dly;

  always_comb begin
    accept  = iValid && (state == FILL || state == RUN);
    lastCol = (col == COL_LAST);
    rdTop   = lb0[col];
    rdMid   = lb1[col];
  end

  // DRAIN ends once nothing is left that could still raise oPixelValid next cycle,
  // so oFrameDone lands directly after the final oPixelValid.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (iStart) nextState = FILL;
      FILL:    if (accept && lastCol && row == RW'(1)) nextState = RUN;
      RUN:     if (accept && lastCol && row == ROW_LAST) nextState = DRAIN;
      default: if (!oWinValid && dly == '0) nextState = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state      <= IDLE;
      oBusy      <= 1'b0;
      oFrameDone <= 1'b0;
      oOrder     <= 4'd5;
      col        <= '0;
      row        <= '0;
    end else begin
      state      <= nextState;
      oBusy      <= (nextState != IDLE);
      oFrameDone <= (state == DRAIN) && (nextState == IDLE);
      if (state == IDLE && iStart) begin
        oOrder <= (iOrderSel == 4'd0 || iOrderSel > 4'd9) ? 4'd5 : iOrderSel;
        col    <= '0;
        row    <= '0;
      end else if (accept) begin
        if (lastCol) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Read-before-write: the old row-1 entry moves down to row-2 as the new pixel lands.
  always_ff @(posedge iClk) begin
    if (accept) begin
      lb0[col] <= lb1[col];
      lb1[col] <= iPixel;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      {oNum1, oNum2, oNum3} <= '0;
      {oNum4, oNum5, oNum6} <= '0;
      {oNum7, oNum8, oNum9} <= '0;
      oWinValid             <= 1'b0;
    end else begin
      oWinValid <= accept && (row >= RW'(2)) && (col >= CW'(2));
      if (accept) begin
        {oNum1, oNum2, oNum3} <= {oNum2, oNum3, rdTop};
        {oNum4, oNum5, oNum6} <= {oNum5, oNum6, rdMid};
        {oNum7, oNum8, oNum9} <= {oNum8, oNum9, iPixel};
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      dly         <= '0;
      oPixel      <= '0;
      oPixelValid <= 1'b0;
    end else begin
      dly[0] <= oWinValid;
      for (int unsigned i = 1; i < SORT_LAT; i++) dly[i] <= dly[i-1];
      oPixelValid <= dly[SORT_LAT-1];
      if (dly[SORT_LAT-1]) oPixel <= iSortValue;
    end
  end

endmodule

// File: tb/tb_rank_window_ctrl.sv
// Directed bench for rank_window_ctrl: 3x3 frames from a vector table on one instance,
// 5x4 ramp frames (continuous, gapped, reset-abort) on a second instance.
module tb_rank_window_ctrl;

  localparam int SL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nVec = 0;
  int nFail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rankOf(input logic [71:0] w, input logic [3:0] k);
    logic [7:0] s[9];
    logic [7:0] t;
    for (int i = 0; i < 9; i++) s[i] = w[(8-i)*8 +: 8];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8 - i; j++)
        if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    if (k < 4'd1 || k > 4'd9) return s[4];
    return s[int'(k) - 1];
  endfunction

  // ---------------- instance A: 3x3 ----------------
  logic rstA, startA, validA, wvA, pvA, busyA, fdA;
  logic [3:0] selA, ordA;
  logic [7:0] pixA, sortA, pA;
  logic [7:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
  logic [71:0] winA;
  logic [7:0] pipeA[SL];
  assign winA  = {a1, a2, a3, a4, a5, a6, a7, a8, a9};
  assign sortA = pipeA[SL-1];
  always @(posedge clk) begin
    pipeA[0] <= rankOf(winA, ordA);
    for (int i = 1; i < SL; i++) pipeA[i] <= pipeA[i-1];
  end

  rank_window_ctrl #(.IMG_W(3), .IMG_H(3), .DATA_W(8), .SORT_LAT(SL)) dutA (
    .iClk(clk), .iRst(rstA), .iStart(startA), .iOrderSel(selA), .iPixel(pixA), .iValid(validA),
    .oNum1(a1), .oNum2(a2), .oNum3(a3), .oNum4(a4), .oNum5(a5), .oNum6(a6),
    .oNum7(a7), .oNum8(a8), .oNum9(a9), .oOrder(ordA), .oWinValid(wvA),
    .iSortValue(sortA), .oPixel(pA), .oPixelValid(pvA), .oBusy(busyA), .oFrameDone(fdA));

  // ---------------- instance B: 5x4 ----------------
  logic rstB, startB, validB, wvB, pvB, busyB, fdB;
  logic [3:0] selB, ordB;
  logic [7:0] pixB, sortB, pB;
  logic [7:0] b1, b2, b3, b4, b5, b6, b7, b8, b9;
  logic [71:0] winB;
  logic [7:0] pipeB[SL];
  assign winB  = {b1, b2, b3, b4, b5, b6, b7, b8, b9};
  assign sortB = pipeB[SL-1];
  always @(posedge clk) begin
    pipeB[0] <= rankOf(winB, ordB);
    for (int i = 1; i < SL; i++) pipeB[i] <= pipeB[i-1];
  end

  rank_window_ctrl #(.IMG_W(5), .IMG_H(4), .DATA_W(8), .SORT_LAT(SL)) dutB (
    .iClk(clk), .iRst(rstB), .iStart(startB), .iOrderSel(selB), .iPixel(pixB), .iValid(validB),
    .oNum1(b1), .oNum2(b2), .oNum3(b3), .oNum4(b4), .oNum5(b5), .oNum6(b6),
    .oNum7(b7), .oNum8(b8), .oNum9(b9), .oOrder(ordB), .oWinValid(wvB),
    .iSortValue(sortB), .oPixel(pB), .oPixelValid(pvB), .oBusy(busyB), .oFrameDone(fdB));

  int wvCntA = 0;
  logic [71:0] winQ[$];
  logic [7:0]  pixQ[$];
  int doneCnt = 0;
  int doneCyc = -1;
  int lastPixCyc = -1;
  always @(negedge clk) begin
    if (wvA) wvCntA++;
    if (wvB) winQ.push_back(winB);
    if (pvB) begin pixQ.push_back(pB); lastPixCyc = cyc; end
    if (fdB) begin doneCnt++; doneCyc = cyc; end
  end

  typedef struct {
    logic [3:0] sel;
    logic [7:0] pix[9];
    logic [3:0] expOrder;
    logic [7:0] expPixel;
  } vec3_t;
  vec3_t tbl[6];

  // 5x4 ramp frame: window k sits at x=2+k%3, y=2+k/3, pixel value = 5*y+x
  task automatic runFrameB(input logic [3:0] sel, input logic [3:0] expOrd, input bit gapped,
                           input bit midStart);
    int d0, x, y;
    logic [7:0] expW, expP;
    winQ.delete();
    pixQ.delete();
    d0 = doneCnt;
    startB = 1'b1; selB = sel;
    step();
    startB = 1'b0;
    chk("B busy after start", busyB, 1);
    chk("B order latched", ordB, expOrd);
    for (int p = 0; p < 20; p++) begin
      validB = 1'b1; pixB = 8'(p);
      if (midStart && p == 12) begin startB = 1'b1; selB = 4'd8; end
      step();
      startB = 1'b0;
      if (gapped && p < 19) begin
        validB = 1'b0; pixB = 8'hEE;
        step();
        chk("B gap winValid low", wvB, 0);
        chk("B gap oNum9 hold", b9, p);
      end
    end
    validB = 1'b0;
    for (int t = 0; t < 60 && doneCnt == d0; t++) step();
    chk("B frame done", doneCnt, d0 + 1);
    chk("B window count", winQ.size(), 6);
    chk("B pixel count", pixQ.size(), 6);
    chk("B done after last pixel", doneCyc, lastPixCyc + 1);
    chk("B order stable", ordB, expOrd);
    for (int k = 0; k < 6 && k < winQ.size(); k++) begin
      x = 2 + k % 3; y = 2 + k / 3;
      for (int j = 0; j < 9; j++) begin
        expW = 8'((y - 2 + j / 3) * 5 + (x - 2 + j % 3));
        chk($sformatf("B win%0d num%0d", k, j + 1), winQ[k][(8-j)*8 +: 8], expW);
      end
      if (k < pixQ.size()) begin
        expP = (expOrd == 4'd3) ? 8'((y - 2) * 5 + x) : 8'((y - 1) * 5 + x - 1);
        chk($sformatf("B pixel%0d", k), pixQ[k], expP);
      end
    end
  endtask

  initial begin
    int gotPix, gotDone, w0;
    logic [7:0] pixVal;

    tbl[0].sel = 4'd7;  tbl[0].pix = '{4,0,9,7,6,4,4,0,4}; tbl[0].expOrder = 4'd7; tbl[0].expPixel = 8'd6;
    tbl[1].sel = 4'd2;  tbl[1].pix = '{4,0,9,7,6,0,4,0,4}; tbl[1].expOrder = 4'd2; tbl[1].expPixel = 8'd0;
    tbl[2].sel = 4'd0;  tbl[2].pix = '{4,0,9,7,6,4,4,0,4}; tbl[2].expOrder = 4'd5; tbl[2].expPixel = 8'd4;
    tbl[3].sel = 4'd12; tbl[3].pix = '{4,0,9,7,6,4,4,0,4}; tbl[3].expOrder = 4'd5; tbl[3].expPixel = 8'd4;
    tbl[4].sel = 4'd1;  tbl[4].pix = '{9,8,7,6,5,4,3,2,1}; tbl[4].expOrder = 4'd1; tbl[4].expPixel = 8'd1;
    tbl[5].sel = 4'd9;  tbl[5].pix = '{9,8,7,6,5,4,3,2,1}; tbl[5].expOrder = 4'd9; tbl[5].expPixel = 8'd9;

    rstA = 1'b0; startA = 1'b0; selA = '0; pixA = '0; validA = 1'b0;
    rstB = 1'b0; startB = 1'b0; selB = '0; pixB = '0; validB = 1'b0;
    #1 rstA = 1'b1; rstB = 1'b1;
    #1;
    chk("A reset order", ordA, 5);
    chk("A reset busy", busyA, 0);
    chk("A reset window", winA, 0);
    chk("A reset valids", {wvA, pvA, fdA}, 0);
    @(negedge clk); @(negedge clk);
    rstA = 1'b0; rstB = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      w0 = wvCntA;
      chk($sformatf("A%0d idle before start", i), busyA, 0);
      startA = 1'b1; selA = tbl[i].sel;
      step();
      startA = 1'b0;
      chk($sformatf("A%0d order", i), ordA, tbl[i].expOrder);
      for (int p = 0; p < 9; p++) begin
        validA = 1'b1; pixA = tbl[i].pix[p];
        step();
      end
      validA = 1'b0;
      chk($sformatf("A%0d winValid", i), wvA, 1);
      for (int j = 0; j < 9; j++)
        chk($sformatf("A%0d num%0d", i, j + 1), winA[(8-j)*8 +: 8], tbl[i].pix[j]);
      gotPix = -1; gotDone = -1; pixVal = 'x;
      for (int k = 2; k < 30 && gotDone < 0; k++) begin
        step();
        if (pvA) begin gotPix = k; pixVal = pA; end
        if (fdA) gotDone = k;
      end
      chk($sformatf("A%0d pixel latency", i), gotPix, SL + 2);
      chk($sformatf("A%0d pixel", i), pixVal, tbl[i].expPixel);
      chk($sformatf("A%0d done latency", i), gotDone, SL + 3);
      chk($sformatf("A%0d window count", i), wvCntA - w0, 1);
      chk($sformatf("A%0d order held", i), ordA, tbl[i].expOrder);
    end

    runFrameB(4'd3, 4'd3, 1'b0, 1'b0);
    runFrameB(4'd5, 4'd5, 1'b1, 1'b1);

    // reset abort mid-RUN with iValid high
    startB = 1'b1; selB = 4'd3;
    step();
    startB = 1'b0;
    for (int p = 0; p < 14; p++) begin
      validB = 1'b1; pixB = 8'(p);
      step();
    end
    chk("B pre-reset order", ordB, 3);
    chk("B pre-reset busy", busyB, 1);
    #2 rstB = 1'b1;
    #1;
    chk("B async reset order", ordB, 5);
    chk("B async reset window", winB, 0);
    chk("B async reset flags", {wvB, pvB, busyB, fdB}, 0);
    chk("B async reset pixel", pB, 0);
    @(negedge clk);
    rstB = 1'b0;
    winQ.delete(); pixQ.delete();
    w0 = doneCnt;
    for (int p = 0; p < 30; p++) begin
      validB = 1'b1; pixB = 8'(p);
      step();
    end
    validB = 1'b0;
    step();
    chk("B post-reset no windows", winQ.size(), 0);
    chk("B post-reset no pixels", pixQ.size(), 0);
    chk("B post-reset idle", busyB, 0);
    chk("B post-reset no done", doneCnt, w0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
